// File: rtl/debounce_scheduler_if.sv
// Button-side and processor-side signals of debounce_scheduler.
// DEBOUNCE_STICKY_EN adds the sticky event/ack pair.
interface debounce_scheduler_if #(
  parameter int N_BTN = 4,
  parameter int IDX_W = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             busy;
  logic [IDX_W-1:0] active_idx;
  logic [1:0]       fsm_state;
`ifdef DEBOUNCE_STICKY_EN
  logic [N_BTN-1:0] event_ack;
  logic [N_BTN-1:0] btn_event;
`endif

  // Valid/ready style does not apply: btn_raw is sampled every cycle, and each
  // bit of btn_press/btn_release is a one-cycle valid with no back-pressure.
  modport master (
    output btn_raw,
    input  btn_stable, btn_press, btn_release, busy, active_idx, fsm_state
`ifdef DEBOUNCE_STICKY_EN
    , output event_ack
    , input  btn_event
`endif
  );

  modport slave (
    input  btn_raw,
    output btn_stable, btn_press, btn_release, busy, active_idx, fsm_state
`ifdef DEBOUNCE_STICKY_EN
    , input  event_ack
    , output btn_event
`endif
  );
endinterface

// File: rtl/debounce_scheduler.sv
// Debounces N_BTN switches with one shared timer granted round-robin.
// Define DEBOUNCE_STICKY_EN to add sticky btn_event flags cleared by event_ack.
module debounce_scheduler #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 20000000,
  parameter int CNT_W           = 26,
  parameter int IDX_W           = 2
) (
  input  logic clock,
  input  logic reset,
  debounce_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, COMMIT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync_b;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rel;
  logic [N_BTN-1:0] req;
  logic [CNT_W-1:0] timer;
  logic [IDX_W-1:0] active_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] pos;
  logic             target;
  logic             found;
`ifdef DEBOUNCE_STICKY_EN
  logic [N_BTN-1:0] event_q;
`endif

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) >= N_BTN - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  assign req = sync_b ^ stable;

  // Walk from rr_ptr around the ring; the first requester wins the timer.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    pos      = rr_ptr;
    for (int k = 0; k < N_BTN; k++) begin
      if (!found && req[pos]) begin
        found    = 1'b1;
        pick_idx = pos;
      end
      pos = wrap_inc(pos);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sync_a     <= '0;
      sync_b     <= '0;
      stable     <= '0;
      press      <= '0;
      rel        <= '0;
      timer      <= '0;
      active_idx <= '0;
      rr_ptr     <= '0;
      target     <= 1'b0;
`ifdef DEBOUNCE_STICKY_EN
      event_q    <= '0;
`endif
    end else begin
      sync_a <= bus.btn_raw;
      sync_b <= sync_a;
      press  <= '0;
      rel    <= '0;
`ifdef DEBOUNCE_STICKY_EN
      event_q <= event_q & ~bus.event_ack;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            active_idx <= pick_idx;
            target     <= sync_b[pick_idx];
            timer      <= '0;
            state      <= COUNT;
          end
        end
        COUNT: begin
          // A bounce gives up the timer and moves the pointer past this button.
          if (sync_b[active_idx] != target) begin
            timer  <= '0;
            rr_ptr <= wrap_inc(active_idx);
            state  <= IDLE;
          end else if (timer == LAST) begin
            state <= COMMIT;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        COMMIT: begin
          stable[active_idx] <= target;
          press[active_idx]  <= target;
          rel[active_idx]    <= ~target;
`ifdef DEBOUNCE_STICKY_EN
          // Written after the ack clear above, so a coincident set wins.
          if (target) event_q[active_idx] <= 1'b1;
`endif
          rr_ptr <= wrap_inc(active_idx);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.btn_stable  = stable;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.busy        = (state != IDLE);
  assign bus.active_idx  = active_idx;
  assign bus.fsm_state   = state;
`ifdef DEBOUNCE_STICKY_EN
  assign bus.btn_event   = event_q;
`endif
endmodule
